axis_frame_gen: RTL
===================

# axis_frame_gen

AXI-Stream frame generator: the transmit end for the team's AXI-Stream slave ports, used to drive FIFOs and adapters in benches and in on-chip self-test. After a start pulse it emits a programmed number of frames with a deterministic byte pattern, a programmable length and an inter-frame gap. It can optionally mark one frame bad via tuser. It obeys tready backpressure strictly and reports progress through busy, done and frame-count outputs.

## Interface
- DATA_WIDTH, 8: tdata width; multiple of 8.
- KEEP_WIDTH, DATA_WIDTH/8: byte lanes.
- KEEP_ENABLE, DATA_WIDTH>8: when 0, tkeep is driven all-ones.
- LEN_WIDTH, 16: width of the frame length in bytes.
- COUNT_WIDTH, 16: width of the frame count and frame index.
- GAP_WIDTH, 8: width of the idle-gap cycle count.
- clk  in  1  clock.
- rst  in  1  reset rst, synchronous, active-high; clock clk.
- start  in  1  one-cycle launch request; honoured only in IDLE.
- abort  in  1  stop at the next frame boundary.
- cfg_len  in  LEN_WIDTH  frame length in bytes; 0 is treated as 1.
- cfg_count  in  COUNT_WIDTH  number of frames; 0 means continuous until abort.
- cfg_gap  in  GAP_WIDTH  idle cycles between frames.
- cfg_bad_en  in  1  enable bad-frame marking.
- cfg_bad_frame  in  COUNT_WIDTH  index of the frame to mark bad.
- m_axis_tdata  out  DATA_WIDTH  payload.
- m_axis_tkeep  out  KEEP_WIDTH  byte enables.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tlast  out  1  last beat of frame.
- m_axis_tuser  out  1  bad-frame flag.
- busy  out  1  generator active.
- done  out  1  one-cycle pulse on completion or abort.
- frames_sent  out  COUNT_WIDTH  frames completed since the last start.

## Operation
- FSM states: IDLE, SEND, GAP.
- IDLE + start: latch all cfg_* signals, clear frames_sent and the frame index, go to SEND. cfg_* changes after the latch have no effect.
- SEND: a beat is transferred when tvalid && tready. tdata, tkeep, tlast and tuser stay stable while tvalid=1 && tready=0. tvalid never drops without a handshake.
- Byte pattern: byte at offset b of frame f = (f[7:0] + b[7:0]) mod 256. Lane i of beat k carries offset k*KEEP_WIDTH+i.
- Beats per frame = ceil(len/KEEP_WIDTH).
- Last beat: tlast=1. tkeep has its low (len mod KEEP_WIDTH) bits set, or all bits when the remainder is 0. Disabled lanes carry 0x00.
- Other beats: tkeep all-ones, tlast=0.
- tuser=1 on every beat of frame f when cfg_bad_en && f==cfg_bad_frame; otherwise 0.
- Last-beat handshake:
  - frame index +1 and frames_sent +1, both wrapping mod 2^COUNT_WIDTH.
  - If this was the final frame (count!=0 && frames_sent+1==count) or abort is pending: go to IDLE and pulse done.
  - Else if gap==0: stay in SEND on the next frame.
  - Else: go to GAP.
- GAP: count gap cycles with tvalid=0, then go to SEND. Abort seen in GAP: go to IDLE next cycle and pulse done.
- Abort in SEND: latched as pending; the current frame completes normally.
- Abort in IDLE: ignored.
- start while busy: ignored.
- Continuous mode (count=0): the frame index wraps; runs until abort.

## Timing
- Reset: all outputs 0 (tvalid, tdata, tkeep, tlast, tuser, busy, done, frames_sent); state IDLE; pending abort cleared. Reset mid-frame drops tvalid the cycle after rst.
- Start latency: start at cycle N → tvalid=1 with beat 0 at N+1; busy=1 from N+1.
- Back-to-back beats: with tready held at 1, one beat per cycle with no bubbles, including across frames when gap=0.
- Gap: last handshake at M with gap G → tvalid=0 during M+1..M+G, next beat 0 at M+G+1.
- Completion: final handshake at M → busy=0, done=1 and final frames_sent visible at M+1; done=0 at M+2.
- frames_sent updates the cycle after each tlast handshake.
- Simultaneous start and abort in IDLE: start wins and abort is ignored.

## Test plan
- DATA_WIDTH=8, len=4, count=2, gap=0, tready=1 → beats 00 01 02 03 / 01 02 03 04; tlast on beats 3 and 7; done at the cycle after beat 7; frames_sent=2.
- DATA_WIDTH=32, len=6 → beat 0 tdata=0x03020100 tkeep=0xF; beat 1 tdata=0x00000504 tkeep=0x3 tlast=1.
- Random tready (50%), len=5, count=3 → tdata/tkeep/tlast stable while stalled; no beat lost or duplicated; byte sequence matches the pattern.
- gap=3, count=2 → exactly 3 cycles of tvalid=0 between the tlast handshake and beat 0 of frame 1.
- cfg_bad_en=1, cfg_bad_frame=1, count=3 → tuser=1 on all beats of frame 1 only.
- count=0, abort asserted mid-frame 5 → frame 5 completes with tlast; done pulses; frames_sent=6; start is ignored while busy.

Source files
------------

// File: rtl/axis_frame_gen_if.sv
// AXI-Stream transmit bundle: payload, byte enables, framing and bad-frame flag.
interface axis_frame_gen_if #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_frame_gen.sv
// AXI-Stream frame generator: first beat one cycle after start, all outputs registered.
// Holds every beat field stable under tready backpressure; abort stops at the next frame boundary.
module axis_frame_gen #(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int LEN_WIDTH   = 16,
    parameter int COUNT_WIDTH = 16,
    parameter int GAP_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [LEN_WIDTH-1:0]   cfg_len,
    input  logic [COUNT_WIDTH-1:0] cfg_count,
    input  logic [GAP_WIDTH-1:0]   cfg_gap,
    input  logic                   cfg_bad_en,
    input  logic [COUNT_WIDTH-1:0] cfg_bad_frame,
    axis_frame_gen_if.master       m_axis,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] frames_sent
);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
    } beat_t;

    localparam logic [LEN_WIDTH:0] KW = (LEN_WIDTH+1)'(KEEP_WIDTH);

    state_t                 state;
    logic [LEN_WIDTH:0]     len_r;
    logic [COUNT_WIDTH-1:0] count_r;
    logic [GAP_WIDTH-1:0]   gap_r;
    logic                   bad_en_r;
    logic [COUNT_WIDTH-1:0] bad_frame_r;
    logic [COUNT_WIDTH-1:0] frame_idx;
    logic [LEN_WIDTH:0]     cur_off;
    logic [GAP_WIDTH-1:0]   gap_cnt;
    logic                   abort_pend;
    beat_t                  beat_q;
    logic                   tvalid_q;
    logic                   tuser_q;

    logic [LEN_WIDTH:0]     start_len;
    logic [COUNT_WIDTH-1:0] frame_nxt;
    logic [LEN_WIDTH:0]     off_nxt;
    logic                   hs;
    logic                   stop;

    // Beat at byte offset 'off' of a frame; lanes past the frame end are disabled and zeroed.
    function automatic beat_t make_beat(input logic [7:0] f, input logic [LEN_WIDTH:0] off,
                                        input logic [LEN_WIDTH:0] len);
        beat_t              b;
        logic [LEN_WIDTH:0] rem;
        rem    = len - off;
        b      = '0;
        b.last = (rem <= KW);
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            if ((LEN_WIDTH+1)'(i) < rem) begin
                b.keep[i]        = 1'b1;
                b.data[8*i +: 8] = f + off[7:0] + 8'(i);
            end
        end
        if (!KEEP_ENABLE) b.keep = '1;
        return b;
    endfunction

    always_comb begin
        start_len = (cfg_len == '0) ? (LEN_WIDTH+1)'(1) : {1'b0, cfg_len};
        frame_nxt = frame_idx + 1'b1;
        off_nxt   = cur_off + KW;
        hs        = tvalid_q && m_axis.tready;
        // abort arriving on the last handshake itself still counts as pending
        stop      = ((count_r != '0) && (frame_nxt == count_r)) || abort_pend || abort;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            len_r       <= '0;
            count_r     <= '0;
            gap_r       <= '0;
            bad_en_r    <= 1'b0;
            bad_frame_r <= '0;
            frame_idx   <= '0;
            cur_off     <= '0;
            gap_cnt     <= '0;
            abort_pend  <= 1'b0;
            beat_q      <= '0;
            tvalid_q    <= 1'b0;
            tuser_q     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_r       <= start_len;
                        count_r     <= cfg_count;
                        gap_r       <= cfg_gap;
                        bad_en_r    <= cfg_bad_en;
                        bad_frame_r <= cfg_bad_frame;
                        frame_idx   <= '0;
                        cur_off     <= '0;
                        abort_pend  <= 1'b0;
                        beat_q      <= make_beat(8'h00, '0, start_len);
                        tuser_q     <= cfg_bad_en && (cfg_bad_frame == '0);
                        tvalid_q    <= 1'b1;
                        busy        <= 1'b1;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (abort) abort_pend <= 1'b1;
                    if (hs) begin
                        if (!beat_q.last) begin
                            cur_off <= off_nxt;
                            beat_q  <= make_beat(frame_idx[7:0], off_nxt, len_r);
                        end else begin
                            frame_idx <= frame_nxt;
                            cur_off   <= '0;
                            if (stop) begin
                                state      <= IDLE;
                                tvalid_q   <= 1'b0;
                                beat_q     <= '0;
                                tuser_q    <= 1'b0;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                abort_pend <= 1'b0;
                            end else if (gap_r == '0) begin
                                beat_q  <= make_beat(frame_nxt[7:0], '0, len_r);
                                tuser_q <= bad_en_r && (frame_nxt == bad_frame_r);
                            end else begin
                                state    <= GAP;
                                tvalid_q <= 1'b0;
                                beat_q   <= '0;
                                tuser_q  <= 1'b0;
                                gap_cnt  <= GAP_WIDTH'(1);
                            end
                        end
                    end
                end
                GAP: begin
                    if (abort || abort_pend) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        abort_pend <= 1'b0;
                    end else if (gap_cnt == gap_r) begin
                        state    <= SEND;
                        tvalid_q <= 1'b1;
                        beat_q   <= make_beat(frame_idx[7:0], '0, len_r);
                        tuser_q  <= bad_en_r && (frame_idx == bad_frame_r);
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m_axis.tdata  = beat_q.data;
    assign m_axis.tkeep  = beat_q.keep;
    assign m_axis.tlast  = beat_q.last;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tuser  = tuser_q;
    assign frames_sent   = frame_idx;
endmodule
